// File: rtl/axi_rfifo_pkg.sv
// Shared types and sizing helpers for the AXI read-data return FIFO.
package axi_rfifo_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_t;

   localparam int RESP_W         = 2;
   localparam int DEF_DEPTH_LOG2 = 10;
   localparam int DEF_PTR_W      = DEF_DEPTH_LOG2 + 1;

   // One beat is packed as {id, resp, last, data}.
   function automatic int BEAT_W(input int data_w, input int id_w);
      return id_w + RESP_W + 1 + data_w;
   endfunction

   // The extra MSB lets full and empty be told apart at equal slots.
   function automatic int PTR_W(input int depth_log2);
      return depth_log2 + 1;
   endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Generic single-clock simple dual-port RAM with a registered read port.
module sdp_ram_1clk
   import axi_rfifo_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
)(
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // The read register only updates on re_i, so it doubles as a hold stage.
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/axi_rdata_fifo_v3.sv
// AXI R-channel return buffer: RAM store, RAM read register, output skid register.
// Define AXI_RFIFO_PKT_MODE_EN to hold beats back until their burst is complete.
module axi_rdata_fifo_v3
   import axi_rfifo_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ID_W       = 4,
   parameter int DEPTH_LOG2 = 10,
   parameter int AFULL_TH   = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [ID_W-1:0]       in_id,
   input  logic [1:0]            in_resp,
   input  logic                  in_last,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [DATA_W-1:0]     rdata,
   output logic [ID_W-1:0]       rid,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  almost_full,
   output logic                  empty
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int PW    = PTR_W(DEPTH_LOG2);
   localparam int BW    = BEAT_W(DATA_W, ID_W);

   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] TH_C    = PW'(AFULL_TH);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      resp_t             resp;
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   if (AFULL_TH >= DEPTH) begin : g_bad_th
      $error("AFULL_TH must be below DEPTH");
   end
   if (DATA_W < 8 || DATA_W > 512) begin : g_bad_dw
      $error("DATA_W out of range");
   end
   if (ID_W < 1 || ID_W > 8) begin : g_bad_idw
      $error("ID_W out of range");
   end

   logic [PW-1:0] wptr_q;
   logic [PW-1:0] wptr_d;
   logic [PW-1:0] rptr_q;
   logic [PW-1:0] rptr_d;
   logic [PW-1:0] count_q;
   logic [PW-1:0] count_d;
   logic          in_ready_q;
   logic          in_ready_d;
   logic          s1_v_q;
   logic          s1_v_d;
   logic          rvalid_q;
   logic          rvalid_d;
   beat_t         out_q;
   beat_t         out_d;

   logic          push;
   logic          pop;
   logic          ram_ne;
   logic          rel_ok;
   logic          out_adv;
   logic          fetch;
   beat_t         wbeat;
   beat_t         s1_beat;
   logic [BW-1:0] ram_rdata;

   always_comb begin
      wbeat      = '0;
      wbeat.id   = in_id;
      wbeat.resp = resp_t'(in_resp);
      wbeat.last = in_last;
      wbeat.data = in_data;
   end

   assign s1_beat = beat_t'(ram_rdata);

   // Stage 1 is the RAM read register; it drains into the output stage
   // whenever the output stage is empty or being popped this cycle.
   always_comb begin
      push    = in_valid & in_ready_q;
      pop     = rvalid_q & rready;
      ram_ne  = (wptr_q != rptr_q);
      out_adv = s1_v_q & (~rvalid_q | rready);
      fetch   = ram_ne & rel_ok & (~s1_v_q | out_adv);
   end

   always_comb begin
      wptr_d     = wptr_q + PW'(push);
      rptr_d     = rptr_q + PW'(fetch);
      count_d    = count_q + PW'(push) - PW'(pop);
      in_ready_d = (count_d != DEPTH_C);
      s1_v_d     = s1_v_q;
      rvalid_d   = rvalid_q;
      out_d      = out_q;
      if (fetch) begin
         s1_v_d = 1'b1;
      end else if (out_adv) begin
         s1_v_d = 1'b0;
      end
      if (out_adv) begin
         rvalid_d = 1'b1;
         out_d    = s1_beat;
      end else if (pop) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         s1_v_q     <= 1'b0;
         rvalid_q   <= 1'b0;
         out_q      <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         s1_v_q     <= s1_v_d;
         rvalid_q   <= rvalid_d;
         out_q      <= out_d;
      end
   end

   sdp_ram_1clk #(
      .WIDTH  (BW),
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q[DEPTH_LOG2-1:0]),
      .wdata_i (wbeat),
      .re_i    (fetch),
      .raddr_i (rptr_q[DEPTH_LOG2-1:0]),
      .rdata_o (ram_rdata)
   );

`ifdef AXI_RFIFO_PKT_MODE_EN
   logic [PW-1:0] bcnt_q;
   logic [PW-1:0] bcnt_d;

   always_comb begin
      bcnt_d = bcnt_q + PW'(push & in_last) - PW'(pop & out_q.last);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end

   assign rel_ok = (bcnt_q != '0);

   // A full FIFO with no complete burst can never drain.
   a_burst_fits : assert property (
      @(posedge clk) disable iff (rst)
      !((count_q == DEPTH_C) && (bcnt_q == '0))
   );
`else
   assign rel_ok = 1'b1;
`endif

   assign in_ready    = in_ready_q;
   assign rvalid      = rvalid_q;
   assign rdata       = out_q.data;
   assign rid         = out_q.id;
   assign rresp       = out_q.resp;
   assign rlast       = out_q.last;
   assign count       = count_q;
   assign almost_full = ((DEPTH_C - count_q) <= TH_C);
   assign empty       = (count_q == '0);

endmodule

// File: tb/tb_axi_rdata_fifo_v3.sv
// Scoreboard bench for axi_rdata_fifo_v3 at DEPTH=16, AFULL_TH=4.
module tb_axi_rdata_fifo_v3;

   localparam int DW  = 16;
   localparam int IW  = 4;
   localparam int DL2 = 4;
   localparam int DEP = 16;
   localparam int TH  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [IW-1:0] in_id = '0;
   logic [1:0]    in_resp = '0;
   logic          in_last = 1'b0;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   logic [IW-1:0] rid;
   logic [1:0]    rresp;
   logic          rlast;
   logic [DL2:0]  count;
   logic          almost_full;
   logic          empty;

   logic rdy_man = 1'b1;
   logic rdy_rnd = 1'b0;
   logic rnd_en  = 1'b0;
   assign rready = rnd_en ? rdy_rnd : rdy_man;

   int errors = 0;
   int checks = 0;
   int pops = 0;
   int slv_seen = 0;
   int since_rel = 0;

   logic [22:0] exp_q[$];
   logic        hold_q = 1'b0;
   logic [22:0] held = '0;

   axi_rdata_fifo_v3 #(
      .DATA_W     (DW),
      .ID_W       (IW),
      .DEPTH_LOG2 (DL2),
      .AFULL_TH   (TH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_id       (in_id),
      .in_resp     (in_resp),
      .in_last     (in_last),
      .rvalid      (rvalid),
      .rready      (rready),
      .rdata       (rdata),
      .rid         (rid),
      .rresp       (rresp),
      .rlast       (rlast),
      .count       (count),
      .almost_full (almost_full),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      rdy_rnd = 1'($urandom_range(0, 1));
   end

   always @(posedge clk or posedge rst) begin
      if (rst) since_rel <= 0;
      else if (since_rel < 3) since_rel <= since_rel + 1;
   end

   // Monitor: mid-cycle view of what the next rising edge will do.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         hold_q = 1'b0;
         chk("rst_rvalid", rvalid, 0);
         chk("rst_count", count, 0);
         chk("rst_empty", empty, 1);
         chk("rst_in_ready", in_ready, 0);
      end else begin
         chk("count", count, exp_q.size());
         chk("empty", empty, exp_q.size() == 0);
         chk("almost_full", almost_full, (DEP - exp_q.size()) <= TH);
         if (since_rel >= 1)
            chk("in_ready", in_ready, exp_q.size() != DEP);
         if (hold_q) begin
            chk("hold_valid", rvalid, 1);
            chk("hold_beat", {rid, rresp, rlast, rdata}, held);
         end
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got %0h expected none",
                        {rid, rresp, rlast, rdata});
            end else begin
               chk("beat", {rid, rresp, rlast, rdata}, exp_q.pop_front());
            end
            pops++;
            if (rresp == 2'd2) slv_seen++;
         end
         if (in_valid && in_ready)
            exp_q.push_back({in_id, in_resp, in_last, in_data});
         hold_q = rvalid && !rready;
         held = {rid, rresp, rlast, rdata};
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id,
                       input logic [1:0] rs, input logic lst,
                       input int maxw, output bit ok);
      bit acc;
      in_valid = 1'b1;
      in_data  = d;
      in_id    = id;
      in_resp  = rs;
      in_last  = lst;
      ok = 1'b0;
      for (int k = 0; k < maxw; k++) begin
         @(negedge clk);
         acc = in_ready && !rst;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int maxc, input string nm);
      int c = 0;
      while (exp_q.size() != 0 && c < maxc) begin
         @(posedge clk);
         #1;
         c++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d beats left, expected 0", nm, exp_q.size());
      end
      chk({nm, "_rvalid"}, rvalid, 0);
   endtask

   initial begin
      bit ok;
      int acc_n;
      int p0;
      int slv_sent;
      logic [1:0] rs;

      // Reset and release
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", rdata, 0);
      chk("rst_rid", rid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_afull", almost_full, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_in_ready", in_ready, 1);

      // Latency and throughput
      rdy_man = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(DW'(i + 1), 4'd3, 2'd0, i == 7, 4, ok);
         chk("lat_accept", ok, 1);
`ifndef AXI_RFIFO_PKT_MODE_EN
         chk("lat_rvalid", rvalid, i >= 2);
`endif
      end
`ifndef AXI_RFIFO_PKT_MODE_EN
      for (int k = 8; k <= 10; k++) begin
         @(posedge clk);
         #1;
         chk("thr_rvalid", rvalid, k <= 9);
      end
`endif
      drain(50, "lat_drain");

      // Full boundary with rready low
      rdy_man = 1'b0;
      acc_n = 0;
      for (int i = 0; i < 20; i++) begin
         send(DW'(16'h0100 + i), 4'(i), 2'd0, i == 15, 4, ok);
         if (ok) acc_n++;
      end
      chk("full_accepted", acc_n, 16);
      chk("full_count", count, 16);
      chk("full_in_ready", in_ready, 0);
      chk("full_afull", almost_full, 1);
      p0 = pops;
      rdy_man = 1'b1;
      drain(100, "full_drain");
      chk("full_pops", pops - p0, 16);

      // Random backpressure with wrap-around
      rnd_en = 1'b1;
      slv_sent = 0;
      slv_seen = 0;
      p0 = pops;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         rs = (i % 7 == 0) ? 2'd2 : 2'($urandom_range(0, 3));
         send(DW'($urandom), IW'($urandom), rs, (i % 8) == 7, 200, ok);
         chk("bp_accept", ok, 1);
         if (ok && rs == 2'd2) slv_sent++;
      end
      drain(3000, "bp_drain");
      chk("bp_pops", pops - p0, 200);
      chk("bp_slverr", slv_seen, slv_sent);
      rnd_en = 1'b0;

      // Reset in the middle of a burst
      rdy_man = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(DW'(16'h0500 + i), 4'd7, 2'd0, 1'b0, 4, ok);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_count", count, 0);
      chk("mid_rvalid", rvalid, 0);
      chk("mid_empty", empty, 1);
      rdy_man = 1'b1;
      p0 = pops;
      for (int i = 0; i < 4; i++) begin
         send(DW'(16'hA000 + i), 4'd5, 2'd0, i == 3, 8, ok);
         chk("mid_accept", ok, 1);
      end
      drain(50, "mid_drain");
      chk("mid_pops", pops - p0, 4);
      chk("mid_count_end", count, 0);

`ifdef AXI_RFIFO_PKT_MODE_EN
      // Burst hold-back
      for (int i = 0; i < 3; i++) begin
         send(DW'(16'hB000 + i), 4'd2, 2'd0, 1'b0, 4, ok);
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk("pkt_hold", rvalid, 0);
      end
      send(16'hB003, 4'd2, 2'd0, 1'b1, 4, ok);
      @(posedge clk);
      #1;
      chk("pkt_rv1", rvalid, 0);
      @(posedge clk);
      #1;
      chk("pkt_rv2", rvalid, 1);
      p0 = pops;
      drain(50, "pkt_drain");
      chk("pkt_pops", pops - p0, 4);
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
